// File: rtl/mlu_pkg.sv
// Shared definitions for the multi-cycle logic unit: op encodings and FSM states.
package mlu_pkg;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_NOR = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/logic_slice.sv
// Combinational CHUNK-bit bitwise slice (AND/OR/XOR/NOR) shared across all slice positions.
module logic_slice
   import mlu_pkg::*;
#(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic [1:0]       op,
   output logic [CHUNK-1:0] r
);

   always_comb begin
      r = '0;
      unique case (op)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_NOR:  r = ~(a | b);
         default: r = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_logic_unit.sv
// Multi-cycle bitwise logic unit: one CHUNK-bit slice per cycle, LSB-first, valid/ready on both sides.
// Optional build macro MLU_PARITY_EN adds a registered parity output of the final result.
module multicycle_logic_unit
   import mlu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output state_t           dbg_state
`ifdef MLU_PARITY_EN
   ,
   output logic             parity
`endif
);

   localparam int NSLICE = WIDTH / CHUNK;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   // Handshake: a transfer happens on a rising edge where valid && ready are both high;
   // in_ready is high only in IDLE, out_valid only in DONE, and neither depends on the other side.
   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic [CHUNK-1:0] slice_a, slice_b, slice_r;
   logic [31:0]      base;
`ifdef MLU_PARITY_EN
   logic             par_run_q, par_run_d;
   logic             parity_q, parity_d;
`endif

   assign base    = 32'(cnt_q) * 32'(CHUNK);
   assign slice_a = a_q[base +: CHUNK];
   assign slice_b = b_q[base +: CHUNK];

   logic_slice #(.CHUNK(CHUNK)) u_slice (
      .a  (slice_a),
      .b  (slice_b),
      .op (op_q),
      .r  (slice_r)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      result_d = result_q;
      zero_d   = zero_q;
`ifdef MLU_PARITY_EN
      par_run_d = par_run_q;
      parity_d  = parity_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = BUSY;
               cnt_d   = '0;
               a_d     = a;
               b_d     = b;
               op_d    = op;
`ifdef MLU_PARITY_EN
               par_run_d = 1'b0;
`endif
            end
         end
         BUSY: begin
            // Bits above the current slice keep stale data; they are hidden until DONE.
            result_d[base +: CHUNK] = slice_r;
`ifdef MLU_PARITY_EN
            par_run_d = par_run_q ^ (^slice_r);
`endif
            if (cnt_q == LAST) begin
               state_d = DONE;
               zero_d  = (result_d == '0);
`ifdef MLU_PARITY_EN
               parity_d = par_run_d;
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
`ifdef MLU_PARITY_EN
         par_run_q <= 1'b0;
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         result_q <= result_d;
         zero_q   <= zero_d;
`ifdef MLU_PARITY_EN
         par_run_q <= par_run_d;
         parity_q  <= parity_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign zero      = zero_q;
   assign dbg_state = state_q;
`ifdef MLU_PARITY_EN
   assign parity    = parity_q;
`endif

endmodule

// File: tb/tb_multicycle_logic_unit.sv
// Self-checking bench for multicycle_logic_unit: 32/4 main instance plus 8/8 and 64/16 sweep instances.
module tb_multicycle_logic_unit;
   import mlu_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int acc_cyc = 0;
   logic [63:0] exp_q[$];

   // main instance, WIDTH=32 CHUNK=4
   logic        in_valid = 1'b0, out_ready = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = '0, b = '0;
   logic        in_ready, out_valid, zero;
   logic [31:0] result;
   state_t      state;
`ifdef MLU_PARITY_EN
   logic        parity, parity8, parity64;
`endif

   // sweep instances
   logic        in_valid8 = 1'b0, out_ready8 = 1'b0, in_ready8, out_valid8, zero8;
   logic [1:0]  op8 = 2'b00;
   logic [7:0]  a8 = '0, b8 = '0, result8;
   state_t      state8;
   logic        in_valid64 = 1'b0, out_ready64 = 1'b0, in_ready64, out_valid64, zero64;
   logic [1:0]  op64 = 2'b00;
   logic [63:0] a64 = '0, b64 = '0, result64;
   state_t      state64;

   multicycle_logic_unit #(.WIDTH(32), .CHUNK(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .zero(zero), .dbg_state(state)
`ifdef MLU_PARITY_EN
      , .parity(parity)
`endif
   );

   multicycle_logic_unit #(.WIDTH(8), .CHUNK(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
      .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
      .zero(zero8), .dbg_state(state8)
`ifdef MLU_PARITY_EN
      , .parity(parity8)
`endif
   );

   multicycle_logic_unit #(.WIDTH(64), .CHUNK(16)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64), .op(op64),
      .a(a64), .b(b64), .out_valid(out_valid64), .out_ready(out_ready64), .result(result64),
      .zero(zero64), .dbg_state(state64)
`ifdef MLU_PARITY_EN
      , .parity(parity64)
`endif
   );

   function automatic logic [31:0] model(input logic [1:0] fop, input logic [31:0] fa, input logic [31:0] fb);
      case (fop)
         OP_AND:  return fa & fb;
         OP_OR:   return fa | fb;
         OP_XOR:  return fa ^ fb;
         default: return ~(fa | fb);
      endcase
   endfunction

   // Drive one op into the main instance; returns just after the accept edge.
   task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic [1:0] top,
                       input logic [31:0] texp);
      int n;
      n = 0;
      a = ta; b = tb_v; op = top; in_valid = 1'b1;
      while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL send_timeout in_ready=%b required=1", in_ready);
      end
      @(posedge clk); #1;
      acc_cyc = cyc;
      in_valid = 1'b0;
      exp_q.push_back({32'h0, texp});
   endtask

   // Wait for the result, check it, hold back-pressure for 'hold' cycles, then hand it off.
   task automatic recv(input int hold, input logic exp_zero, input int exp_lat);
      int n;
      logic busy_ready_low;
      logic [63:0] e64;
      logic [31:0] r0;
      logic z0;
      n = 0;
      busy_ready_low = 1'b1;
      while (!out_valid && n < 200) begin
         if (in_ready !== 1'b0) busy_ready_low = 1'b0;
         @(posedge clk); #1; n++;
      end
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL recv_timeout out_valid=%b required=1", out_valid); end
      checks++;
      if (cyc - acc_cyc != exp_lat) begin
         errors++; $display("FAIL latency got=%0d required=%0d", cyc - acc_cyc, exp_lat);
      end
      checks++;
      if (!busy_ready_low) begin errors++; $display("FAIL in_ready_busy got=1 required=0"); end
      checks++;
      if (exp_q.size() == 0) begin
         errors++; $display("FAIL scoreboard_empty result=%h", result);
      end else begin
         e64 = exp_q.pop_front();
         if (result !== e64[31:0]) begin
            errors++; $display("FAIL result got=%h required=%h", result, e64[31:0]);
         end
      end
      checks++;
      if (zero !== exp_zero) begin errors++; $display("FAIL zero got=%b required=%b", zero, exp_zero); end
      r0 = result; z0 = zero;
      for (int i = 0; i < hold; i++) begin
         out_ready = 1'b0;
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || result !== r0 || zero !== z0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_stable cycle=%0d out_valid=%b result=%h zero=%b in_ready=%b required 1/%h/%b/0",
                     i, out_valid, result, zero, in_ready, r0, z0);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== r0 || state !== IDLE) begin
         errors++;
         $display("FAIL handshake out_valid=%b in_ready=%b result=%h state=%0d required 0/1/%h/IDLE",
                  out_valid, in_ready, result, state, r0);
      end
   endtask

   task automatic test_reset;
      #12;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 || zero !== 1'b0 || state !== IDLE) begin
         errors++;
         $display("FAIL reset_state in_ready=%b out_valid=%b result=%h zero=%b state=%0d required 1/0/0/0/IDLE",
                  in_ready, out_valid, result, zero, state);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_xor;
      out_ready = 1'b0;
      send(32'hFFFF0000, 32'h0F0F0F0F, OP_XOR, 32'hF0F00F0F);
      checks++;
      if (state !== BUSY) begin errors++; $display("FAIL busy_state got=%0d required=BUSY", state); end
      recv(0, 1'b0, 8);
   endtask

   task automatic test_back_to_back;
      logic [1:0]  ops [4];
      logic [31:0] exps[4];
      int prev;
      ops  = '{OP_AND, OP_OR, OP_XOR, OP_NOR};
      exps = '{32'h05050505, 32'hAFAFAFAF, 32'hAAAAAAAA, 32'h50505050};
      prev = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(32'hA5A5A5A5, 32'h0F0F0F0F, ops[i], exps[i]);
         if (i > 0) begin
            checks++;
            if (acc_cyc - prev != 10) begin
               errors++; $display("FAIL b2b_spacing op=%0d got=%0d required=10", i, acc_cyc - prev);
            end
         end
         prev = acc_cyc;
         recv(0, 1'b0, 8);
      end
   endtask

   task automatic test_random;
      logic [31:0] ra, rb, e;
      logic [1:0]  rop;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         ra  = $urandom;
         rb  = (i == 5) ? ra : $urandom;
         rop = 2'($urandom_range(0, 3));
         if (i == 5) rop = OP_XOR;
         e = model(rop, ra, rb);
         send(ra, rb, rop, e);
         recv($urandom_range(0, 2), (e == 32'h0), 8);
      end
   endtask

   task automatic test_backpressure;
      int hs;
      out_ready = 1'b0;
      send(32'h12345678, 32'h12345678, OP_XOR, 32'h0);
      a = 32'hDEADBEEF; b = 32'h0; op = OP_OR; in_valid = 1'b1;
      recv(5, 1'b1, 8);
      hs = cyc;
      send(32'hDEADBEEF, 32'h0, OP_OR, 32'hDEADBEEF);
      checks++;
      if (acc_cyc - hs != 1) begin
         errors++; $display("FAIL accept_after_handshake got=%0d required=1", acc_cyc - hs);
      end
      recv(0, 1'b0, 8);
   endtask

   task automatic test_reset_mid_busy;
      out_ready = 1'b1;
      send(32'h12345678, 32'h87654321, OP_OR, 32'h97755779);
      repeat (3) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0 || zero !== 1'b0 || state !== IDLE) begin
         errors++;
         $display("FAIL reset_mid_busy out_valid=%b in_ready=%b result=%h zero=%b state=%0d required 0/1/0/0/IDLE",
                  out_valid, in_ready, result, zero, state);
      end
      exp_q.delete();
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      send(32'hF0000000, 32'h0000000F, OP_OR, 32'hF000000F);
      recv(0, 1'b0, 8);
   endtask

   task automatic test_sweep_w8;
      int n, acc;
      logic [63:0] e64;
      a8 = 8'hC3; b8 = 8'hFF; op8 = OP_NOR; in_valid8 = 1'b1; out_ready8 = 1'b0;
      @(posedge clk); #1;
      acc = cyc; in_valid8 = 1'b0;
      exp_q.push_back(64'h0);
      n = 0;
      while (!out_valid8 && n < 50) begin @(posedge clk); #1; n++; end
      e64 = exp_q.pop_front();
      checks++;
      if (out_valid8 !== 1'b1 || cyc - acc != 1) begin
         errors++; $display("FAIL w8_latency out_valid=%b got=%0d required=1", out_valid8, cyc - acc);
      end
      checks++;
      if (result8 !== e64[7:0] || zero8 !== 1'b1) begin
         errors++; $display("FAIL w8_result got=%h/%b required=%h/1", result8, zero8, e64[7:0]);
      end
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
      checks++;
      if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
         errors++; $display("FAIL w8_handshake out_valid=%b in_ready=%b required 0/1", out_valid8, in_ready8);
      end
   endtask

   task automatic test_sweep_w64;
      int n, acc;
      logic [63:0] e64;
      a64 = '1; b64 = '0; op64 = OP_AND; in_valid64 = 1'b1; out_ready64 = 1'b0;
      @(posedge clk); #1;
      acc = cyc; in_valid64 = 1'b0;
      exp_q.push_back(64'h0);
      n = 0;
      while (!out_valid64 && n < 50) begin @(posedge clk); #1; n++; end
      e64 = exp_q.pop_front();
      checks++;
      if (out_valid64 !== 1'b1 || cyc - acc != 4) begin
         errors++; $display("FAIL w64_latency out_valid=%b got=%0d required=4", out_valid64, cyc - acc);
      end
      checks++;
      if (result64 !== e64 || zero64 !== 1'b1) begin
         errors++; $display("FAIL w64_result got=%h/%b required=%h/1", result64, zero64, e64);
      end
      out_ready64 = 1'b1;
      @(posedge clk); #1;
      out_ready64 = 1'b0;
      checks++;
      if (out_valid64 !== 1'b0 || in_ready64 !== 1'b1) begin
         errors++; $display("FAIL w64_handshake out_valid=%b in_ready=%b required 0/1", out_valid64, in_ready64);
      end
   endtask

`ifdef MLU_PARITY_EN
   task automatic test_parity;
      out_ready = 1'b1;
      send(32'h00000007, 32'h0, OP_OR, 32'h00000007);
      recv(0, 1'b0, 8);
      checks++;
      if (parity !== 1'b1) begin errors++; $display("FAIL parity_odd got=%b required=1", parity); end
      send(32'h00000003, 32'h0, OP_OR, 32'h00000003);
      recv(0, 1'b0, 8);
      checks++;
      if (parity !== 1'b0) begin errors++; $display("FAIL parity_even got=%b required=0", parity); end
   endtask
`endif

   initial begin
      test_reset();
      test_xor();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_busy();
      test_random();
      test_sweep_w8();
      test_sweep_w64();
`ifdef MLU_PARITY_EN
      test_parity();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog_timeout time=%0t required=finish", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/multicycle_logic_unit.md
Name: multicycle_logic_unit

Overview:
- Parametrised, multi-cycle bitwise logic unit for the Mini-MIPS ALU datapath.
- Generalises the fixed 32-bit XOR to WIDTH bits and four ops: AND, OR, XOR, NOR.
- Works one CHUNK-bit slice per cycle through a single shared slice.
- Valid/ready handshakes on input and output, so the ALU can stall it and it can back-pressure the ALU.

Parameters:
- WIDTH, 32: operand/result width; must be a positive multiple of CHUNK.
- CHUNK, 4: bits processed per cycle; 1 <= CHUNK <= WIDTH.
- NSLICE, WIDTH/CHUNK (derived localparam, not overridable): slice count and compute latency in cycles.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand/op valid.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  2  00 AND, 01 OR, 10 XOR, 11 NOR.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  bitwise result.
- zero  out  1  result == 0.

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, result=0, zero=0; slice counter and captured operands/op cleared.
- Accept: on a rising edge with in_valid && in_ready, capture a, b and op; counter=0; state -> BUSY. Inputs are ignored afterwards until the next IDLE.
- BUSY, each cycle:
  - result[idx*CHUNK +: CHUNK] <= f(op, a_slice, b_slice), where idx = counter.
  - Slices are written LSB-first.
  - Result bits above the current slice hold their old value. They are not observable because out_valid=0.
  - When counter == NSLICE-1: state -> DONE, out_valid=1. Otherwise counter+1.
- Latency: out_valid rises exactly NSLICE clock edges after the accept edge (8 for 32/4).
- DONE:
  - result and zero are stable while out_valid=1 && !out_ready.
  - On out_valid && out_ready: state -> IDLE, out_valid=0; result is held.
- zero: registered, updated on entry to DONE (computed from the final result including the last slice); held otherwise.
- No accept is possible in BUSY or DONE; in_ready=0, so a new in_valid waits. There is no accept in the same cycle as the DONE->IDLE handoff; in_ready rises the cycle after.
- Throughput: one op per NSLICE+2 cycles when out_ready is held high.
- CHUNK == WIDTH: NSLICE=1, so BUSY lasts 1 cycle.
- Counter width: $clog2(NSLICE), minimum 1 bit. Wrap-around is never used; the counter is reset on accept.
- Reset mid-BUSY or mid-DONE: immediate return to reset values; the in-flight operation is discarded with no output.
- Ops are purely bitwise; there is no carry between slices.

Optional Feature:
- Macro: MLU_PARITY_EN.
- Defined:
  - Adds output port parity (out, 1) = XOR-reduction of the final result.
  - Registered alongside zero, on entry to DONE; reset value 0; held in IDLE.
  - Computed incrementally: a running XOR per slice, cleared on accept.
- Undefined: no parity port and no extra logic; all other behaviour identical.

Decomposition:
- Shared package mlu_pkg:
  - op encoding constants OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOR=2'b11;
  - state typedef {IDLE, BUSY, DONE}.
- One natural combinational sub-module: logic_slice #(CHUNK) (a, b, op -> r).
  - Single instance, fed by a CHUNK-wide mux on the captured operands.
- The FSM, counter and result register stay in the top module.

Test Plan:
- Reset then XOR, WIDTH=32, CHUNK=4: a=0xFFFF0000, b=0x0F0F0F0F, op=10 -> out_valid exactly 8 edges after accept; result=0xF0F00F0F; zero=0; in_ready=0 throughout.
- All ops, a=0xA5A5A5A5, b=0x0F0F0F0F, back-to-back with out_ready=1:
  - AND=0x05050505, OR=0xAFAFAFAF, XOR=0xAAAAAAAA, NOR=0x50505050;
  - each new accept occurs 10 cycles after the previous one.
- Zero flag and back-pressure: a=b=0x12345678, op=XOR -> result=0, zero=1; hold out_ready=0 for 5 cycles -> out_valid, result and zero stable; in_valid held high is not accepted until the cycle after the handshake.
- Reset mid-BUSY: accept OR, drop rst_n after 3 BUSY cycles -> out_valid=0, in_ready=1, result=0 immediately; a fresh op after release completes normally.
- Parameter sweep:
  - WIDTH=8, CHUNK=8: a=0xC3, b=0xFF, op=NOR -> result=0x00, zero=1, latency 1.
  - WIDTH=64, CHUNK=16: a=all ones, b=0, op=AND -> result=0, latency 4.
- With MLU_PARITY_EN: a=0x00000007, b=0, op=OR -> result=0x7, parity=1; then a=0x3, b=0, op=OR -> parity=0.
